pc_seq: RTL and testbench
=========================

// Module: pc_seq
// PURPOSE
//   Program-counter sequencer for the single-cycle CPU datapath. Replaces the fixed
//   10-bit PC register, +1 adder, jump mux and one-deep return stack with one block.
//   Adds parametrised address width and call depth, conditional jumps on the Z/C
//   flags, stall, and stack overflow/underflow detection with a sticky HALT state.
//   Drives the program-memory address. Takes control strobes from the control unit.
// PARAMETERS
//   AW         10  PC / program-memory address width in bits
//   DEPTH       8  return-stack entries (>=2)
//   RESET_ADDR  0  PC value loaded on reset
// PORTS
//   clk        in   1          clock, rising edge
//   reset      in   1          synchronous, active-high
//   stall      in   1          hold PC and stack this cycle
//   jump       in   1          jump request, qualified by jcond
//   jcond      in   2          00 always, 01 if z, 10 if !z, 11 if carry
//   z          in   1          registered zero flag from datapath
//   carry      in   1          registered carry flag from datapath
//   call       in   1          push pc+1 and go to target
//   ret        in   1          pop top of stack into PC
//   target     in   AW         jump/call destination
//   pc         out  AW         current PC (registered)
//   level      out  clog2(DEPTH+1)  number of valid stack entries
//   full       out  1          level == DEPTH
//   empty      out  1          level == 0
//   err_ovf    out  1          sticky: call while full
//   err_unf    out  1          sticky: ret while empty
//   halted     out  1          FSM in HALT
// BEHAVIOUR
//   Reset (sync, highest priority): pc=RESET_ADDR, level=0, err_*=0, state=RUN.
//     Stack RAM contents are not cleared.
//   FSM: RUN -> HALT on an overflow or underflow event. HALT -> RUN only on reset.
//     In HALT, pc, level and the stack are frozen and all strobes are ignored.
//   In RUN, each rising edge applies the first matching rule:
//     1. stall=1: no change.
//     2. ret=1: if empty, set err_unf, enter HALT, pc unchanged.
//        Otherwise pc<=stack[level-1] and level<=level-1.
//        A call asserted in the same cycle is ignored.
//     3. call=1: if full, set err_ovf, enter HALT, pc unchanged.
//        Otherwise stack[level]<=pc+1, level<=level+1, pc<=target. jump is ignored.
//     4. jump=1 and condition true: pc<=target.
//     5. Otherwise: pc<=pc+1.
//   Arithmetic: pc+1 is modulo 2^AW, so the all-ones address wraps to 0.
//     The pushed return address wraps the same way.
//   Latency: decisions use inputs sampled at the edge. The new pc is visible one
//     cycle after the strobe. Flag inputs are taken as presented; there is no
//     internal flag pipeline.
//   full, empty and halted are combinational decodes of registered state.
//     err_ovf and err_unf are registered.
//   Reset asserted mid-call or mid-ret wins outright: no push or pop occurs.
// TESTING
//   Reset -> pc=0, level=0, empty=1. Then 5 idle cycles -> pc=5.
//   pc=3FF, idle edge -> pc=000. call at pc=3FF, target=020 -> pc=020, pushed value=000.
//   Nested: call 100 at pc=010, then call 200 -> level=2. ret -> pc=101. ret -> pc=011, empty=1.
//   jump target=050 jcond=01: z=0 -> pc+1; z=1 -> pc=050. Same for jcond=11 with carry.
//   DEPTH=8: 8 calls -> full=1. 9th call -> err_ovf=1, halted=1, pc frozen.
//     Further strobes have no effect. reset -> RUN, pc=0.
//   ret while empty -> err_unf=1, halted=1. stall=1 during call -> no push, pc unchanged.

Source files
------------

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter sequencer with conditional jumps and a call/return stack
module pc_seq #(
    parameter int AW         = 10,
    parameter int DEPTH      = 8,
    parameter int RESET_ADDR = 0,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          jump,
    input  logic [1:0]    jcond,
    input  logic          z,
    input  logic          carry,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          err_ovf,
    output logic          err_unf,
    output logic          halted
);
    localparam int SW = $clog2(DEPTH);
    localparam logic [AW-1:0] LP_RESET = AW'(RESET_ADDR);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [LW-1:0] r_level;
    logic          r_err_ovf;
    logic          r_err_unf;
    logic [AW-1:0] r_stack [DEPTH];

    logic [AW-1:0] w_pc_inc;
    logic [SW-1:0] w_push_idx;
    logic [SW-1:0] w_top_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_cond;

    assign w_pc_inc   = r_pc + AW'(1);
    assign w_push_idx = r_level[SW-1:0];
    assign w_top_idx  = w_push_idx - SW'(1);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_empty    = (r_level == '0);

    always_comb begin
        w_cond = 1'b0;
        case (jcond)
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = z;
            2'b10:   w_cond = ~z;
            default: w_cond = carry;
        endcase
    end

    // Stack RAM is deliberately left out of reset; only the level pointer is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_pc      <= LP_RESET;
            r_level   <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (r_state == S_RUN && !stall) begin
            if (ret) begin
                if (w_empty) begin
                    r_err_unf <= 1'b1;
                    r_state   <= S_HALT;
                end else begin
                    r_pc    <= r_stack[w_top_idx];
                    r_level <= r_level - LW'(1);
                end
            end else if (call) begin
                if (w_full) begin
                    r_err_ovf <= 1'b1;
                    r_state   <= S_HALT;
                end else begin
                    r_stack[w_push_idx] <= w_pc_inc;
                    r_level             <= r_level + LW'(1);
                    r_pc                <= target;
                end
            end else if (jump && w_cond) begin
                r_pc <= target;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign pc      = r_pc;
    assign level   = r_level;
    assign full    = w_full;
    assign empty   = w_empty;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
    assign halted  = (r_state == S_HALT);
endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq with a pc scoreboard
module tb_pc_seq;
    logic       clk = 1'b0;
    logic       reset, stall, jump, z, carry, call, ret;
    logic [1:0] jcond;
    logic [9:0] target;
    logic [9:0] pc;
    logic [3:0] level;
    logic       full, empty, err_ovf, err_unf, halted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] q_exp [$];
    logic [9:0] q_obs [$];
    logic [9:0] e, o;

    // Reference model state
    logic [9:0] m_pc;
    int         m_level;
    logic       m_halt;
    logic [9:0] m_stk [8];

    pc_seq dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jcond(jcond),
        .z(z), .carry(carry), .call(call), .ret(ret), .target(target),
        .pc(pc), .level(level), .full(full), .empty(empty),
        .err_ovf(err_ovf), .err_unf(err_unf), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic rst, input logic st, input logic jp, input logic [1:0] jc,
                         input logic zz, input logic cc, input logic cl, input logic rt,
                         input logic [9:0] tg);
        logic cond;
        reset = rst; stall = st; jump = jp; jcond = jc; z = zz; carry = cc;
        call = cl; ret = rt; target = tg;
        case (jc)
            2'b00:   cond = 1'b1;
            2'b01:   cond = zz;
            2'b10:   cond = !zz;
            default: cond = cc;
        endcase
        if (rst) begin
            m_pc = 10'h000; m_level = 0; m_halt = 1'b0;
        end else if (!m_halt && !st) begin
            if (rt) begin
                if (m_level == 0) m_halt = 1'b1;
                else begin m_level = m_level - 1; m_pc = m_stk[m_level]; end
            end else if (cl) begin
                if (m_level == 8) m_halt = 1'b1;
                else begin m_stk[m_level] = m_pc + 10'd1; m_level = m_level + 1; m_pc = tg; end
            end else if (jp && cond) m_pc = tg;
            else m_pc = m_pc + 10'd1;
        end
        q_exp.push_back(m_pc);
        @(posedge clk);
        #1;
        q_obs.push_back(pc);
        reset = 1'b0; stall = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        n_checks++; if (pc !== 10'h000) begin $display("FAIL reset_pc got %h want 000", pc); n_fail++; end
        n_checks++; if (level !== 4'd0 || empty !== 1'b1 || halted !== 1'b0 || err_ovf !== 1'b0 || err_unf !== 1'b0) begin
            $display("FAIL reset_state got level=%0d empty=%b halted=%b ovf=%b unf=%b want 0 1 0 0 0", level, empty, halted, err_ovf, err_unf); n_fail++; end
        idle(5);
        n_checks++; if (pc !== 10'h005) begin $display("FAIL idle5_pc got %h want 005", pc); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL reset_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_wrap;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 10'h3FF);
        idle(1);
        n_checks++; if (pc !== 10'h000) begin $display("FAIL wrap_pc got %h want 000", pc); n_fail++; end
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 10'h3FF);
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'h020);
        n_checks++; if (pc !== 10'h020 || level !== 4'd1) begin $display("FAIL wrap_call got pc=%h level=%0d want 020 1", pc, level); n_fail++; end
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 10'h000);
        n_checks++; if (pc !== 10'h000) begin $display("FAIL wrap_pushed got %h want 000", pc); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL wrap_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_nested;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 10'h010);
        drive(0, 0, 1, 2'b00, 0, 0, 1, 0, 10'h100);
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'h200);
        n_checks++; if (level !== 4'd2 || pc !== 10'h200) begin $display("FAIL nested_level got level=%0d pc=%h want 2 200", level, pc); n_fail++; end
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 10'h000);
        n_checks++; if (pc !== 10'h101) begin $display("FAIL nested_ret1 got %h want 101", pc); n_fail++; end
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 10'h000);
        n_checks++; if (pc !== 10'h011 || empty !== 1'b1) begin $display("FAIL nested_ret2 got pc=%h empty=%b want 011 1", pc, empty); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL nested_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_cond_jump;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        drive(0, 0, 1, 2'b01, 0, 0, 0, 0, 10'h050);
        n_checks++; if (pc !== 10'h001) begin $display("FAIL jz_not_taken got %h want 001", pc); n_fail++; end
        drive(0, 0, 1, 2'b01, 1, 0, 0, 0, 10'h050);
        n_checks++; if (pc !== 10'h050) begin $display("FAIL jz_taken got %h want 050", pc); n_fail++; end
        drive(0, 0, 1, 2'b11, 1, 0, 0, 0, 10'h050);
        n_checks++; if (pc !== 10'h051) begin $display("FAIL jc_not_taken got %h want 051", pc); n_fail++; end
        drive(0, 0, 1, 2'b11, 0, 1, 0, 0, 10'h050);
        n_checks++; if (pc !== 10'h050) begin $display("FAIL jc_taken got %h want 050", pc); n_fail++; end
        drive(0, 0, 1, 2'b10, 1, 0, 0, 0, 10'h0A0);
        drive(0, 0, 1, 2'b10, 0, 0, 0, 0, 10'h0A0);
        n_checks++; if (pc !== 10'h0A0) begin $display("FAIL jnz_taken got %h want 0a0", pc); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL cond_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_overflow;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'((i + 1) * 16));
        n_checks++; if (full !== 1'b1 || level !== 4'd8) begin $display("FAIL ovf_full got full=%b level=%0d want 1 8", full, level); n_fail++; end
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'h300);
        n_checks++; if (err_ovf !== 1'b1 || halted !== 1'b1 || pc !== 10'h080) begin
            $display("FAIL ovf_halt got ovf=%b halted=%b pc=%h want 1 1 080", err_ovf, halted, pc); n_fail++; end
        drive(0, 0, 1, 2'b00, 0, 0, 0, 0, 10'h123);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 10'h000);
        idle(2);
        n_checks++; if (pc !== 10'h080 || level !== 4'd8 || halted !== 1'b1) begin
            $display("FAIL ovf_frozen got pc=%h level=%0d halted=%b want 080 8 1", pc, level, halted); n_fail++; end
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        n_checks++; if (halted !== 1'b0 || pc !== 10'h000 || err_ovf !== 1'b0) begin
            $display("FAIL ovf_reset got halted=%b pc=%h ovf=%b want 0 000 0", halted, pc, err_ovf); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL ovf_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_underflow_stall;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1, 10'h000);
        n_checks++; if (err_unf !== 1'b1 || halted !== 1'b1 || pc !== 10'h000) begin
            $display("FAIL unf_halt got unf=%b halted=%b pc=%h want 1 1 000", err_unf, halted, pc); n_fail++; end
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        idle(2);
        drive(0, 1, 0, 2'b00, 0, 0, 1, 0, 10'h030);
        n_checks++; if (pc !== 10'h002 || level !== 4'd0) begin $display("FAIL stall_call got pc=%h level=%0d want 002 0", pc, level); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL unf_sb got %h want %h", o, e); n_fail++; end end
    endtask

    task automatic test_back_to_back;
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 10'h000);
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'h040);
        drive(0, 0, 0, 2'b00, 0, 0, 1, 1, 10'h070);
        n_checks++; if (pc !== 10'h001 || level !== 4'd0) begin $display("FAIL ret_wins got pc=%h level=%0d want 001 0", pc, level); n_fail++; end
        drive(0, 0, 0, 2'b00, 0, 0, 1, 0, 10'h040);
        drive(1, 0, 0, 2'b00, 0, 0, 1, 0, 10'h090);
        n_checks++; if (pc !== 10'h000 || level !== 4'd0) begin $display("FAIL reset_mid_call got pc=%h level=%0d want 000 0", pc, level); n_fail++; end
        while (q_exp.size() > 0) begin e = q_exp.pop_front(); o = q_obs.pop_front(); n_checks++;
            if (o !== e) begin $display("FAIL b2b_sb got %h want %h", o, e); n_fail++; end end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; jump = 1'b0; jcond = 2'b00; z = 1'b0; carry = 1'b0;
        call = 1'b0; ret = 1'b0; target = 10'h000;
        m_pc = 10'h000; m_level = 0; m_halt = 1'b0;
        test_reset;
        test_wrap;
        test_nested;
        test_cond_jump;
        test_overflow;
        test_underflow_stall;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
